// File: rtl/mem_pkg.sv
// mcDefs: shared constants and FSM encoding for the paged burst memory.
`default_nettype none

package mcDefs;

    localparam logic [3:0] MEMPAGE1  = 4'h2;
    localparam int         ADDR_W    = 16;
    localparam int         DATA_W    = 16;
    localparam int         PAGE_W    = 4;
    localparam int         OFFSET_W  = 12;
    localparam int         BURST_LEN = 4;
    localparam int         BEAT_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// mem_array: 4096 x 16 storage, synchronous write port, asynchronous read port.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_array
    import mcDefs::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [OFFSET_W-1:0] rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] storage [1 << OFFSET_W];

    // No reset on contents: data survives an aborted burst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    assign rd_data = storage[rd_addr];

endmodule

`default_nettype wire

// File: rtl/mem.sv
// ============================================================================
// mem: paged 4-beat burst memory on a multiplexed address/data bus.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem
    import mcDefs::*;
#(
    parameter logic [PAGE_W-1:0] PAGE = MEMPAGE1
)
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              AddrValid,
    input  logic              rw,
    inout  wire  [DATA_W-1:0] AddrData
);

    state_t              state;
    logic [OFFSET_W-1:0] offset;
    logic [BEAT_W-1:0]   beat;
    logic                drive_en;

    logic                page_hit;
    logic                last_beat;
    logic [OFFSET_W-1:0] beat_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                wr_en;

    assign page_hit  = AddrValid && (AddrData[ADDR_W-1:OFFSET_W] == PAGE);
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
    // Offset arithmetic wraps naturally within the 12-bit page.
    assign beat_addr = offset + OFFSET_W'(beat);
    assign wr_en     = (state == WRITE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            offset   <= '0;
            beat     <= '0;
            drive_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (page_hit) begin
                        offset   <= AddrData[OFFSET_W-1:0];
                        state    <= rw ? READ : WRITE;
                        drive_en <= rw;
                    end
                end
                READ, WRITE: begin
                    // AddrValid is deliberately ignored until the burst ends.
                    if (last_beat) begin
                        state    <= IDLE;
                        beat     <= '0;
                        drive_en <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat     <= '0;
                    drive_en <= 1'b0;
                end
            endcase
        end
    end

    mem_array u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (beat_addr),
        .wr_data (AddrData),
        .rd_addr (beat_addr),
        .rd_data (rd_data)
    );

    assign AddrData = drive_en ? rd_data : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_mem.sv
// tb_mem: random and directed bursts against an array model; a monitor checks
// read beats from a scoreboard queue and bus ownership in every other cycle.
`default_nettype none

module tb_mem;

    localparam logic [3:0] PG = 4'h2;

    logic        clk;
    logic        resetN;
    logic        AddrValid;
    logic        rw;
    wire  [15:0] AddrData;

    logic        tb_oe;
    logic [15:0] tb_data;
    logic        rd_beat;

    logic [15:0] model   [4096];
    bit          written [4096];
    logic [15:0] exp_q   [$];

    int tests;
    int fails;

    assign AddrData = tb_oe ? tb_data : 16'hzzzz;

    mem #(.PAGE(PG)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .AddrValid (AddrValid),
        .rw        (rw),
        .AddrData  (AddrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: read beats pop the scoreboard; any other cycle the bench owns
    // the bus, so it must read back exactly what the bench drives.
    always @(negedge clk) begin
        if (resetN) begin
            if (rd_beat) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_beat: bus=%h but no expected value queued", AddrData);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (AddrData !== e) begin
                        fails++;
                        $display("FAIL rd_data: got %h expected %h at %0t", AddrData, e, $time);
                    end
                end
            end else if (tb_oe) begin
                tests++;
                if (AddrData !== tb_data) begin
                    fails++;
                    $display("FAIL bus_own: bus=%h master drove %h at %0t", AddrData, tb_data, $time);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [3:0] pg, input logic [11:0] off, input logic is_rd,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input bit mid, input bit b2b);
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        AddrValid = 1'b1;
        rw        = is_rd;
        tb_oe     = 1'b1;
        rd_beat   = 1'b0;
        tb_data   = {pg, off};
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            logic [11:0] a;
            a = off + 12'(b);
            AddrValid = mid && (b == 1);
            if (mid) rw = 1'($urandom_range(0, 1));
            if (is_rd && pg == PG) begin
                tb_oe   = 1'b0;
                rd_beat = 1'b1;
                exp_q.push_back(model[a]);
            end else begin
                tb_oe   = 1'b1;
                rd_beat = 1'b0;
                tb_data = is_rd ? 16'($urandom) : d[b];
                if (!is_rd && pg == PG) begin
                    model[a]   = d[b];
                    written[a] = 1'b1;
                end
            end
            next_cycle();
        end
        AddrValid = 1'b0;
        rd_beat   = 1'b0;
        tb_oe     = 1'b1;
        tb_data   = 16'($urandom);
        if (!b2b) next_cycle();
    endtask

    task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        resetN    = 1'b0;
        AddrValid = 1'b0;
        rw        = 1'b0;
        tb_oe     = 1'b1;
        tb_data   = 16'h1234;
        rd_beat   = 1'b0;
        foreach (written[i]) written[i] = 1'b0;

        #1;
        check_eq("reset_bus_free", AddrData, 16'h1234);
        next_cycle();
        next_cycle();
        resetN = 1'b1;

        // Basic write/read burst.
        burst(PG, 12'h010, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);
        burst(PG, 12'h010, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Foreign page: no write, no drive.
        burst(4'h5, 12'h010, 1'b0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 1'b0, 1'b0);
        burst(4'h5, 12'h010, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        burst(PG, 12'h010, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Offset wrap at the top of the page.
        burst(PG, 12'h000, 1'b0, 16'hE0E0, 16'hE1E1, 16'hE2E2, 16'hE3E3, 1'b0, 1'b0);
        burst(PG, 12'hFFE, 1'b0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0, 1'b0);
        burst(PG, 12'hFFE, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        burst(PG, 12'h000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Reset in the middle of a read burst.
        AddrValid = 1'b1;
        rw        = 1'b1;
        tb_oe     = 1'b1;
        tb_data   = {PG, 12'h010};
        next_cycle();
        AddrValid = 1'b0;
        tb_oe     = 1'b0;
        rd_beat   = 1'b1;
        exp_q.push_back(model[12'h010]);
        next_cycle();
        exp_q.push_back(model[12'h011]);
        next_cycle();
        resetN  = 1'b0;
        rd_beat = 1'b0;
        #1;
        tb_oe   = 1'b1;
        tb_data = 16'hA5C3;
        #1;
        check_eq("reset_release", AddrData, 16'hA5C3);
        check_eq("reset_q_empty", 16'(exp_q.size()), 16'd0);
        next_cycle();
        resetN = 1'b1;
        burst(PG, 12'h010, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Back-to-back write then read with a stray mid-burst AddrValid.
        burst(PG, 12'h100, 1'b0, 16'h2100, 16'h2101, 16'h2102, 16'h2103, 1'b1, 1'b1);
        burst(PG, 12'h100, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);

        // Randomised bursts.
        for (int n = 0; n < 60; n++) begin
            logic [11:0] off;
            logic [3:0]  pg;
            logic        is_rd;
            off   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4090, 4095))
                                                : 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) < 3) off = 12'h100;
            pg    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : PG;
            is_rd = 1'($urandom_range(0, 1));
            if (is_rd && pg == PG) begin
                for (int b = 0; b < 4; b++) begin
                    if (!written[12'(off + 12'(b))]) is_rd = 1'b0;
                end
            end
            burst(pg, off, is_rd, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        next_cycle();
        check_eq("final_q_empty", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
